clock_sequencer: RTL and testbench

Parametrised CPU clock-enable generator for the CTI-8 core. A configurable chain of divide-by-DIV prescaler stages provides free-running ticks from the system clock. A run/halt/burst state machine turns the selected tick, or a debounced single-step button, into a one-cycle `enable` pulse that drives every CPU register. It adds breakpoint halt, N-instruction bursts and glitch-free rate changes.

---
 rtl/clock_seq_pkg.sv | 21 ++
 rtl/step_debouncer.sv | 60 ++++++
 rtl/clock_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_clock_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_seq_pkg.sv
// Shared types, defaults and helpers for the CTI-8 clock-enable sequencer.
package clock_seq_pkg;

    // Sequencer modes: stopped, free-running, counted burst.
    typedef enum logic [1:0] {
        HALT  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2
    } seq_state_t;

    localparam int DEFAULT_NUM_STAGES      = 6;
    localparam int DEFAULT_DIV             = 10;
    localparam int DEFAULT_BURST_W         = 8;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 100000;

    // Rates beyond the slowest stage select the slowest stage.
    function automatic int clamp_rate(input int rate, input int num_stages);
        return (rate > num_stages) ? num_stages : rate;
    endfunction

endpackage

// File: rtl/step_debouncer.sv
// Single-step push-button conditioner: 2-flop synchroniser, stability
// counter and a registered one-cycle pulse on the debounced rising edge.
module step_debouncer #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic step_raw,
    output logic step_rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             db_dly_q, db_dly_d;
    logic             rise_q, rise_d;

    // Accept the synchronised level once it has differed from the debounced
    // level for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
    always_comb begin
        sync1_d  = step_raw;
        sync2_d  = sync1_q;
        db_d     = db_q;
        cnt_d    = '0;
        db_dly_d = db_q;
        rise_d   = db_q & ~db_dly_q;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Register bank for the whole step path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            db_dly_q <= db_dly_d;
            rise_q   <= rise_d;
        end
    end

    assign step_rise = rise_q;

endmodule

// File: rtl/clock_sequencer.sv
// CPU clock-enable generator: free-running decade prescaler chain plus a
// HALT/RUN/BURST sequencer producing a registered one-cycle enable.
module clock_sequencer
    import clock_seq_pkg::*;
#(
    parameter int NUM_STAGES      = DEFAULT_NUM_STAGES,
    parameter int DIV             = DEFAULT_DIV,
    parameter int BURST_W         = DEFAULT_BURST_W,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int RATE_W          = $clog2(NUM_STAGES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RATE_W-1:0]  rate,
    input  logic               run,
    input  logic               step,
    input  logic               burst_start,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               halt_req,
    output logic               enable,
    output logic               running,
    output logic               burst_done
);

    localparam int CNT_W = $clog2(DIV);

    logic [NUM_STAGES:1] stage_max;
    logic [NUM_STAGES:0] tick;
    logic                sel_tick;
    logic                step_rise;
    logic                run_rise;
    logic [RATE_W-1:0]   rate_clamped;

    seq_state_t          state_q, state_d;
    logic [RATE_W-1:0]   rate_q, rate_d;
    logic [BURST_W-1:0]  count_q, count_d;
    logic                run_prev_q, run_prev_d;
    logic                enable_q, enable_d;
    logic                running_q, running_d;
    logic                burst_done_q, burst_done_d;
    logic                done_pend_q, done_pend_d;

    assign tick[0] = 1'b1;

    // Stage k wraps once every DIV^k clocks; a tick is an all-stages-at-max AND.
    generate
        for (genvar gi = 1; gi <= NUM_STAGES; gi++) begin : g_stage
            logic [CNT_W-1:0] cnt_q, cnt_d;

            assign stage_max[gi] = (cnt_q == CNT_W'(DIV - 1));
            assign tick[gi]      = &stage_max[gi:1];

            // Advance only when the next-faster stage ticks.
            always_comb begin
                cnt_d = cnt_q;
                if (tick[gi-1]) begin
                    cnt_d = stage_max[gi] ? '0 : cnt_q + CNT_W'(1);
                end
            end

            // Stage counter register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    // Pick the tick addressed by the active rate.
    always_comb begin
        sel_tick = 1'b0;
        for (int k = 0; k <= NUM_STAGES; k++) begin
            if (rate_q == RATE_W'(k)) begin
                sel_tick = tick[k];
            end
        end
    end

    assign rate_clamped = RATE_W'(clamp_rate(int'(rate), NUM_STAGES));
    assign run_rise     = run & ~run_prev_q;

    step_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_debouncer (
        .clk      (clk),
        .rst      (rst),
        .step_raw (step),
        .step_rise(step_rise)
    );

    // Next-state and output decode; the rate only switches on a period
    // boundary while enables are flowing, so no period is cut short.
    always_comb begin
        state_d      = state_q;
        rate_d       = rate_q;
        count_d      = count_q;
        run_prev_d   = run;
        enable_d     = 1'b0;
        done_pend_d  = 1'b0;
        burst_done_d = done_pend_q;
        case (state_q)
            HALT: begin
                rate_d = rate_clamped;
                if (halt_req) begin
                    state_d = HALT;
                end else if (run_rise) begin
                    state_d = RUN;
                end else if (burst_start) begin
                    if (burst_len != '0) begin
                        state_d = BURST;
                        count_d = burst_len;
                    end else begin
                        burst_done_d = 1'b1;
                    end
                end else begin
                    enable_d = step_rise;
                end
            end
            RUN: begin
                if (sel_tick) begin
                    rate_d = rate_clamped;
                end
                if (halt_req || !run) begin
                    state_d = HALT;
                end else begin
                    enable_d = sel_tick;
                end
            end
            BURST: begin
                if (sel_tick) begin
                    rate_d = rate_clamped;
                end
                if (halt_req) begin
                    state_d = HALT;
                end else if (sel_tick) begin
                    enable_d = 1'b1;
                    count_d  = count_q - BURST_W'(1);
                    if (count_q == BURST_W'(1)) begin
                        state_d     = HALT;
                        done_pend_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
        running_d = (state_d != HALT);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HALT;
            rate_q       <= RATE_W'(NUM_STAGES);
            count_q      <= '0;
            run_prev_q   <= 1'b0;
            enable_q     <= 1'b0;
            running_q    <= 1'b0;
            burst_done_q <= 1'b0;
            done_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rate_q       <= rate_d;
            count_q      <= count_d;
            run_prev_q   <= run_prev_d;
            enable_q     <= enable_d;
            running_q    <= running_d;
            burst_done_q <= burst_done_d;
            done_pend_q  <= done_pend_d;
        end
    end

    assign enable     = enable_q;
    assign running    = running_q;
    assign burst_done = burst_done_q;

endmodule

// File: tb/tb_clock_sequencer.sv
// Directed bench for clock_sequencer: rate sweep table, burst table and
// hand-written breakpoint, rate-change, debounce and reset sequences.
module tb_clock_sequencer;
    import clock_seq_pkg::*;

    localparam int NS  = 3;
    localparam int DV  = 10;
    localparam int BW  = 8;
    localparam int DBC = 4;
    localparam int RW  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] rate;
    logic          run;
    logic          step;
    logic          burst_start;
    logic [BW-1:0] burst_len;
    logic          halt_req;
    logic          enable;
    logic          running;
    logic          burst_done;

    clock_sequencer #(
        .NUM_STAGES     (NS),
        .DIV            (DV),
        .BURST_W        (BW),
        .DEBOUNCE_CYCLES(DBC),
        .RATE_W         (RW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rate       (rate),
        .run        (run),
        .step       (step),
        .burst_start(burst_start),
        .burst_len  (burst_len),
        .halt_req   (halt_req),
        .enable     (enable),
        .running    (running),
        .burst_done (burst_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int rate;
        int gap;
    } rate_vec_t;

    typedef struct {
        int len;
        int n_en;
    } burst_vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end else begin
            $display("ok   %s: %0d", name, actual);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout, expected an enable within budget", name);
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    // Returns number of clock edges until enable is seen, or -1 on timeout.
    task automatic wait_enable(input int budget, output int cyc);
        int  n;
        bit  found;
        n     = 0;
        found = 1'b0;
        while (!found && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (enable === 1'b1) found = 1'b1;
        end
        cyc = found ? n : -1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got time limit, expected $finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rate_vec_t  rv [5];
        burst_vec_t bv [3];
        int c, cnt, en_cnt, en_at, done_cnt, done_at, last_en, bad_gap, exp_done;

        rv[0] = '{2, 100};
        rv[1] = '{0, 1};
        rv[2] = '{7, 1000};
        rv[3] = '{1, 10};
        rv[4] = '{3, 1000};
        bv[0] = '{5, 5};
        bv[1] = '{0, 0};
        bv[2] = '{1, 1};

        rst = 1'b1; rate = '0; run = 1'b0; step = 1'b0;
        burst_start = 1'b0; burst_len = '0; halt_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset enable", 32'(enable), 0);
        check("reset running", 32'(running), 0);
        check("reset burst_done", 32'(burst_done), 0);
        check("reset state", 32'(dut.state_q), 32'(HALT));
        check("reset rate_q", 32'(dut.rate_q), 3);
        rst = 1'b0;

        // ---- rate sweep table ----
        rate = RW'(rv[0].rate);
        run  = 1'b1;
        step_cycle();
        check("run start running", 32'(running), 1);
        for (int i = 0; i < 5; i++) begin
            rate = RW'(rv[i].rate);
            wait_enable(2500, c);
            if (c < 0) timeout_fail($sformatf("rate %0d load", rv[i].rate));
            wait_enable(2500, c);
            if (c < 0) timeout_fail($sformatf("rate %0d align", rv[i].rate));
            for (int j = 0; j < 2; j++) begin
                wait_enable(2500, c);
                check($sformatf("gap rate=%0d #%0d", rv[i].rate, j), 32'(c), 32'(rv[i].gap));
            end
        end

        // ---- rate change mid-period 3 -> 1 ----
        cnt = 0;
        repeat (500) begin
            step_cycle();
            if (enable) cnt++;
        end
        check("ratechg no early enable", 32'(cnt), 0);
        rate = RW'(1);
        wait_enable(1000, c);
        check("ratechg period end", 32'(c), 500);
        wait_enable(50, c);
        check("ratechg new gap #0", 32'(c), 10);
        wait_enable(50, c);
        check("ratechg new gap #1", 32'(c), 10);
        run = 1'b0;
        step_cycle();
        step_cycle();
        check("run low running", 32'(running), 0);

        // ---- burst table (rate 1) ----
        for (int i = 0; i < 3; i++) begin
            burst_len   = BW'(bv[i].len);
            burst_start = 1'b1;
            step_cycle();
            burst_start = 1'b0;
            if (bv[i].len != 0) check($sformatf("burst %0d running", bv[i].len), 32'(running), 1);
            en_cnt = 0; done_cnt = 0; done_at = -1; last_en = -1; bad_gap = 0;
            for (int n = 0; n < 80; n++) begin
                if (enable) begin
                    if (last_en >= 0 && n - last_en != DV) bad_gap++;
                    last_en = n;
                    en_cnt++;
                end
                if (burst_done) begin
                    done_cnt++;
                    done_at = n;
                end
                step_cycle();
            end
            exp_done = (bv[i].n_en == 0) ? 0 : last_en + 1;
            check($sformatf("burst %0d enables", bv[i].len), 32'(en_cnt), 32'(bv[i].n_en));
            check($sformatf("burst %0d bad gaps", bv[i].len), 32'(bad_gap), 0);
            check($sformatf("burst %0d done count", bv[i].len), 32'(done_cnt), 1);
            check($sformatf("burst %0d done cycle", bv[i].len), 32'(done_at), 32'(exp_done));
            check($sformatf("burst %0d end state", bv[i].len), 32'(dut.state_q), 32'(HALT));
        end

        // ---- breakpoint at rate 0 ----
        rate = RW'(0);
        run  = 1'b1;
        step_cycle();
        step_cycle();
        check("bp enable before halt", 32'(enable), 1);
        halt_req = 1'b1;
        step_cycle();
        halt_req = 1'b0;
        check("bp suppressed enable", 32'(enable), 0);
        check("bp running", 32'(running), 0);
        cnt = 0;
        repeat (20) begin
            step_cycle();
            if (enable) cnt++;
        end
        check("bp enables while run held", 32'(cnt), 0);
        check("bp state", 32'(dut.state_q), 32'(HALT));
        run = 1'b0;
        step_cycle();
        run = 1'b1;
        step_cycle();
        check("bp resume running", 32'(running), 1);
        step_cycle();
        check("bp resume enable", 32'(enable), 1);
        run = 1'b0;
        step_cycle();
        step_cycle();

        // ---- step debounce in HALT: 1-0-1 bounce then hold ----
        step   = 1'b1;
        en_cnt = 0;
        en_at  = -1;
        for (int n = 1; n <= 20; n++) begin
            step_cycle();
            if (enable) begin
                en_cnt++;
                en_at = n;
            end
            if (n == 2) step = 1'b0;
            if (n == 4) step = 1'b1;
        end
        check("step enable count", 32'(en_cnt), 1);
        check("step enable cycle", 32'(en_at), 32'(4 + 2 + DBC + 1 + 1));
        step = 1'b0;
        cnt  = 0;
        repeat (15) begin
            step_cycle();
            if (enable) cnt++;
        end
        check("step release enables", 32'(cnt), 0);

        // ---- step while running is ignored ----
        rate = RW'(2);
        run  = 1'b1;
        wait_enable(300, c);
        if (c < 0) timeout_fail("step-in-run sync");
        step = 1'b1;
        cnt  = 0;
        repeat (20) begin
            step_cycle();
            if (enable) cnt++;
        end
        check("step in run enables", 32'(cnt), 0);
        step = 1'b0;
        run  = 1'b0;
        repeat (15) step_cycle();

        // ---- reset in the middle of a burst ----
        rate        = RW'(1);
        burst_len   = BW'(5);
        burst_start = 1'b1;
        step_cycle();
        burst_start = 1'b0;
        wait_enable(50, c);
        if (c < 0) timeout_fail("rst burst enable 1");
        wait_enable(50, c);
        if (c < 0) timeout_fail("rst burst enable 2");
        rst = 1'b1;
        #1;
        check("rst async enable", 32'(enable), 0);
        check("rst async running", 32'(running), 0);
        check("rst async burst_done", 32'(burst_done), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst release state", 32'(dut.state_q), 32'(HALT));
        check("rst release rate_q", 32'(dut.rate_q), 3);
        en_cnt   = 0;
        done_cnt = 0;
        repeat (40) begin
            step_cycle();
            if (enable) en_cnt++;
            if (burst_done) done_cnt++;
        end
        check("rst after enables", 32'(en_cnt), 0);
        check("rst after burst_done", 32'(done_cnt), 0);
        check("rst after running", 32'(running), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
